// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - time-multiplexed 7-segment scan controller with shared decoder
// Optional leading-zero blanking is compiled in when SEG7_SCAN_LZB_EN is defined.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL        = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [3:0]              dec_bcd,
    input  logic [6:0]              seg_in,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    bad_code
);

    localparam int CNT_MAX = (DWELL > BLANK_CYCLES) ? DWELL : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] SHOW  = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [6:0]              seg_q, seg_d;
    logic                    fd_q, fd_d;
    logic                    bad_q, bad_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic                    pv_q, pv_d;

    logic [3:0] cur_code;
    logic       code_bad;
    logic       suppress;
    logic       blank_last;
    logic       show_last;
    logic       last_idx;

    assign cur_code   = active_q[{idx_q, 2'b00} +: 4];
    assign code_bad   = (cur_code > 4'd9);
    assign blank_last = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
    assign show_last  = (cnt_q == CNT_W'(DWELL - 1));
    assign last_idx   = (idx_q == IDX_W'(NUM_DIGITS - 1));

`ifdef SEG7_SCAN_LZB_EN
    // A digit is a leading zero when it and every higher-index digit are zero; digit 0 always shows.
    always_comb begin
        logic upper_nz;
        upper_nz = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= int'(idx_q)) && (active_q[4*i +: 4] != 4'd0)) upper_nz = 1'b1;
        end
        suppress = (idx_q != '0) && !upper_nz;
    end
`else
    assign suppress = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        seg_d    = seg_q;
        fd_d     = 1'b0;
        bad_d    = bad_q;
        active_d = active_q;
        pend_d   = pend_q;
        pv_d     = pv_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                seg_d = '0;
                if (en) state_d = BLANK;
            end
            BLANK: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    seg_d   = '0;
                end else if (blank_last) begin
                    // The decoder output is undefined for 10..15, so it is never selected for those codes.
                    state_d = SHOW;
                    cnt_d   = '0;
                    seg_d   = (code_bad || suppress) ? 7'd0 : seg_in;
                    if (code_bad) bad_d = 1'b1;
                end
            end
            SHOW: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    seg_d   = '0;
                end else if (show_last) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    seg_d   = '0;
                    if (last_idx) begin
                        idx_d = '0;
                        fd_d  = 1'b1;
                        if (pv_q) begin
                            active_d = pend_q;
                            pv_d     = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                seg_d   = '0;
            end
        endcase

        // A load on the wrap cycle lands after the commit above, so the old pending is what goes live.
        if (load) begin
            pend_d = digits_in;
            pv_d   = 1'b1;
            if (state_q == IDLE) active_d = digits_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            seg_q    <= '0;
            fd_q     <= 1'b0;
            bad_q    <= 1'b0;
            active_q <= '0;
            pend_q   <= '0;
            pv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            fd_q     <= fd_d;
            bad_q    <= bad_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            pv_q     <= pv_d;
        end
    end

    assign dec_bcd    = cur_code;
    assign seg_out    = seg_q;
    assign dig_sel    = (state_q == SHOW) ? (NUM_DIGITS'(1) << idx_q) : '0;
    assign busy       = (state_q != IDLE);
    assign frame_done = fd_q;
    assign bad_code   = bad_q;

endmodule
